fetch_sequencer: RTL

//  Owns the fetch PC and sequences the instruction bus (ibus_req_t/ibus_resp_t) one request at a time.

---
 rtl/fetch_sequencer_pkg.sv | 41 ++++
 rtl/fetch_sequencer_buffer.sv | 49 ++++
 rtl/fetch_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: bus request/response, decode content,
// FSM states, FIFO entry, reset PC and a PC-step helper.
package fetch_sequencer_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'hbfc0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        is_delay_slot;
    logic [4:0]  exc_code;
    logic        exc_valid;
  } content_t;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_sequencer_buffer.sv
// Small power-of-two FIFO of fetched words; flush empties it and overrides
// any push or pop in the same cycle.
module fetch_buffer
  import fetch_sequencer_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t        mem_r [DEPTH];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [CW-1:0]       count_r;

  // Storage, pointers and occupancy; callers never push when full or pop when empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_entry;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop) rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner and single-outstanding instruction-bus sequencer feeding decode.
// Optional FETCH_PERF_EN adds the stall_cnt port and its saturating counter.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output content_t    out_cont
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t  state_r, state_s, seq_state_s;
  logic [31:0]   pc_r, pc_s;
  logic [31:0]   target_r, target_s;
  logic          kill_r, kill_s;
  ibus_req_t     ireq_r;
  logic          done_s, push_s, pop_s, flush_s, out_valid_s;
  logic [CW-1:0] count_s, count_after_s;
  fetch_entry_t  push_entry_s, head_s;
  content_t      out_cont_s;

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush_s),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .count      (count_s)
  );

  // Next-state, PC, kill/target and FIFO control.
  always_comb begin
    seq_state_s        = state_r;
    pc_s               = pc_r;
    kill_s             = kill_r;
    target_s           = target_r;
    done_s             = 1'b0;
    push_s             = 1'b0;
    flush_s            = redirect_valid;
    pop_s              = out_valid_s & out_ready & ~redirect_valid;
    push_entry_s.pc    = pc_r;
    push_entry_s.instr = iresp.data;
    case (state_r)
      IDLE: begin
        if (redirect_valid) pc_s = redirect_pc;
        else pc_s = pc_r;
      end
      REQ: begin
        if (iresp.addr_ok && iresp.data_ok) done_s = 1'b1;
        else if (iresp.addr_ok) seq_state_s = WAIT;
        else seq_state_s = REQ;
      end
      WAIT: begin
        if (iresp.data_ok) done_s = 1'b1;
        else seq_state_s = WAIT;
      end
      default: seq_state_s = IDLE;
    endcase
    // A completing response is dropped if killed or redirected in the same cycle.
    if (done_s) begin
      kill_s = 1'b0;
      if (redirect_valid) pc_s = redirect_pc;
      else if (kill_r) pc_s = target_r;
      else begin
        pc_s   = next_seq_pc(pc_r);
        push_s = 1'b1;
      end
    end else if (redirect_valid && (state_r != IDLE)) begin
      kill_s   = 1'b1;
      target_s = redirect_pc;
    end else begin
      kill_s = kill_r;
    end
    count_after_s = flush_s ? '0 : (count_s + CW'(push_s) - CW'(pop_s));
    if (done_s || (state_r == IDLE)) begin
      if (count_after_s < CW'(BUF_DEPTH)) state_s = REQ;
      else state_s = IDLE;
    end else begin
      state_s = seq_state_s;
    end
  end

  // FSM, PC, kill/target and the registered bus request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= IDLE;
      pc_r     <= RESET_PC;
      kill_r   <= 1'b0;
      target_r <= 32'd0;
      ireq_r   <= '0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      kill_r       <= kill_s;
      target_r     <= target_s;
      ireq_r.valid <= (state_s == REQ);
      ireq_r.addr  <= pc_s;
    end
  end

  assign out_valid_s = (count_s != '0);

  // Decode content: only pc and instr carry data; everything is zero when empty.
  always_comb begin
    out_cont_s = '0;
    if (out_valid_s) begin
      out_cont_s.pc    = head_s.pc;
      out_cont_s.instr = head_s.instr;
    end else begin
      out_cont_s = '0;
    end
  end

  assign ireq      = ireq_r;
  assign out_valid = out_valid_s;
  assign out_cont  = out_cont_s;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles with nothing for decode and no redirect.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_r <= 32'd0;
    end else if (!out_valid_s && !redirect_valid && (stall_cnt_r != 32'hffff_ffff)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule
